// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin / fixed-priority arbiter.
package arb_pkg;

   // Arbiter ownership state
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Arbitration mode selector values
   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

endpackage : arb_pkg

// File: rtl/rot_prio_enc.sv
// Rotating MSB-first priority encoder.
// Rotates req so that bit ptr sits at the MSB, picks the highest set bit,
// then maps that position back to the original requester index.
//   req   : request vector (already masked for eligibility)
//   ptr   : index that gets top priority; N-1 gives plain fixed priority
//   found : at least one request set
//   idx   : winning requester index, 0 when found is low
module rot_prio_enc #(
   parameter int unsigned N   = 8,
   parameter int unsigned IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic           found,
   output logic [IDW-1:0] idx
);

   logic [N-1:0] rot;

   // rot[N-1-k] holds the requester k steps below ptr (modulo N)
   always_comb begin
      rot = '0;
      for (int k = 0; k < N; k++) begin
         rot[N-1-k] = req[ptr - IDW'(k)];
      end
   end

   // Highest set rotated bit wins; position j maps back to ptr + j + 1
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int j = 0; j < N; j++) begin
         if (rot[j]) begin
            found = 1'b1;
            idx   = ptr + IDW'(j) + IDW'(1);
         end
      end
   end

endmodule : rot_prio_enc

// File: rtl/rr_priority_arbiter.sv
// Single-resource arbiter with fixed-priority or round-robin selection,
// registered one-hot grant, and a hold-time limit that forces release.
//   clk, rst_n : clock, asynchronous active-low reset
//   mode       : 0 fixed priority (N-1 highest), 1 round-robin
//   req        : level requests, held until served
//   done       : single-cycle release pulse from the owner
//   gnt        : registered one-hot grant
//   gnt_id     : index of the current (or last) owner
//   gnt_valid  : a grant is active
//   timeout    : one-cycle pulse after a forced release
module rr_priority_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned N        = 8,
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned IDW      = $clog2(N),
   parameter int unsigned CNTW     = $clog2(MAX_HOLD)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           mode,
   input  logic [N-1:0]   req,
   input  logic           done,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           gnt_valid,
   output logic           timeout
);

   localparam logic [N-1:0]    ONE_HOT0  = N'(1);
   localparam logic [IDW-1:0]  TOP_IDX   = IDW'(N - 1);
   localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(MAX_HOLD - 1);

   state_t          state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [CNTW-1:0] hold_cnt_q, hold_cnt_d;
   logic [N-1:0]    gnt_d;
   logic [IDW-1:0]  gnt_id_d;
   logic            gnt_valid_d;
   logic            timeout_d;

   logic            busy;
   logic            owner_req;
   logic            at_limit;
   logic            release_now;
   logic            force_rel;
   logic            arbitrate;
   logic            take;
   logic [N-1:0]    eligible;
   logic [IDW-1:0]  enc_ptr;
   logic            win_found;
   logic [IDW-1:0]  win_idx;

   // Release detection; done has precedence so a done at the limit is not a timeout
   always_comb begin
      busy        = (state_q == BUSY);
      owner_req   = req[gnt_id];
      at_limit    = (hold_cnt_q == HOLD_LAST);
      release_now = busy & (done | ~owner_req | at_limit);
      force_rel   = busy & at_limit & ~done & owner_req;
      arbitrate   = ~busy | release_now;
      // A timed-out owner sits out only the arbitration of its own release
      eligible    = force_rel ? (req & ~(ONE_HOT0 << gnt_id)) : req;
      enc_ptr     = (mode == MODE_RR) ? ptr_q : TOP_IDX;
   end

   rot_prio_enc #(
      .N   (N),
      .IDW (IDW)
   ) u_enc (
      .req   (eligible),
      .ptr   (enc_ptr),
      .found (win_found),
      .idx   (win_idx)
   );

   assign take = arbitrate & win_found;

   // State register plus all registered outputs and datapath state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= TOP_IDX;
         hold_cnt_q <= '0;
         gnt        <= '0;
         gnt_id     <= '0;
         gnt_valid  <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         gnt        <= gnt_d;
         gnt_id     <= gnt_id_d;
         gnt_valid  <= gnt_valid_d;
         timeout    <= timeout_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (take) state_d = BUSY;
         BUSY: if (release_now) state_d = take ? BUSY : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of grant, pointer, hold counter and timeout pulse
   always_comb begin
      gnt_d       = gnt;
      gnt_id_d    = gnt_id;
      gnt_valid_d = gnt_valid;
      ptr_d       = ptr_q;
      hold_cnt_d  = hold_cnt_q;
      timeout_d   = force_rel;
      if (take) begin
         gnt_d       = ONE_HOT0 << win_idx;
         gnt_id_d    = win_idx;
         gnt_valid_d = 1'b1;
         ptr_d       = (win_idx == '0) ? TOP_IDX : (win_idx - IDW'(1));
         hold_cnt_d  = '0;
      end else if (release_now) begin
         // gnt_id keeps the last owner for observability
         gnt_d       = '0;
         gnt_valid_d = 1'b0;
         hold_cnt_d  = '0;
      end else if (busy) begin
         hold_cnt_d  = hold_cnt_q + CNTW'(1);
      end
   end

   // Structural invariants of the grant outputs
   a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
   a_valid_match: assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (|gnt));
   a_id_match:    assert property (@(posedge clk) disable iff (!rst_n) gnt_valid |-> gnt[gnt_id]);
   a_to_pulse:    assert property (@(posedge clk) disable iff (!rst_n) timeout |=> !timeout);

endmodule : rr_priority_arbiter

// File: tb/tb_rr_priority_arbiter.sv
// Directed self-checking bench for rr_priority_arbiter (N=8, MAX_HOLD=4).
module tb_rr_priority_arbiter;
   import arb_pkg::*;

   localparam int unsigned N        = 8;
   localparam int unsigned MAX_HOLD = 4;
   localparam int unsigned IDW      = $clog2(N);

   logic           clk;
   logic           rst_n;
   logic           mode;
   logic [N-1:0]   req;
   logic           done;
   logic [N-1:0]   gnt;
   logic [IDW-1:0] gnt_id;
   logic           gnt_valid;
   logic           timeout;

   int n_checks = 0;
   int n_fail   = 0;

   rr_priority_arbiter #(
      .N        (N),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [7:0] e_gnt, input int e_id,
                            input logic e_valid, input logic e_to);
      check({tag, ".gnt"},       32'(gnt),       32'(e_gnt));
      check({tag, ".gnt_id"},    32'(gnt_id),    32'(e_id));
      check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(e_valid));
      check({tag, ".timeout"},   32'(timeout),   32'(e_to));
   endtask

   initial begin
      int rr_ids [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

      rst_n = 1'b0;
      mode  = MODE_FIXED;
      req   = '0;
      done  = 1'b0;
      #12;
      check_out("reset", 8'h00, 0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step();
      check_out("idle_after_reset", 8'h00, 0, 1'b0, 1'b0);

      // Round-robin sweep from the reset pointer; done held high (ignored while IDLE)
      mode = MODE_RR;
      req  = 8'hFF;
      done = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step();
         check_out($sformatf("rr_%0d", i), 8'(1 << rr_ids[i]), rr_ids[i], 1'b1, 1'b0);
      end
      done = 1'b0;
      req  = '0;
      step();
      check_out("rr_drain", 8'h00, 7, 1'b0, 1'b0);

      // Fixed priority with a zero-bubble handoff on done
      mode = MODE_FIXED;
      req  = 8'b0100_1000;
      step();
      check_out("fix_first", 8'b0100_0000, 6, 1'b1, 1'b0);
      req  = 8'b0000_1000;
      done = 1'b1;
      step();
      check_out("fix_handoff", 8'b0000_1000, 3, 1'b1, 1'b0);
      done = 1'b0;
      req  = '0;
      step();
      check_out("fix_drop", 8'h00, 3, 1'b0, 1'b0);

      // Lone requester hits the hold limit, sits out one cycle, then is regranted
      req = 8'b0000_0100;
      step();
      check_out("to_grant", 8'h04, 2, 1'b1, 1'b0);
      for (int i = 1; i < 4; i++) begin
         step();
         check_out($sformatf("to_hold_%0d", i), 8'h04, 2, 1'b1, 1'b0);
      end
      step();
      check_out("to_force", 8'h00, 2, 1'b0, 1'b1);
      step();
      check_out("to_regrant", 8'h04, 2, 1'b1, 1'b0);
      // Counter restarted: three more held cycles before the next forced release
      for (int i = 1; i < 4; i++) begin
         step();
         check_out($sformatf("to_rehold_%0d", i), 8'h04, 2, 1'b1, 1'b0);
      end
      step();
      check_out("to_reforce", 8'h00, 2, 1'b0, 1'b1);

      // Forced release hands over to a waiting contender at the same edge
      req = 8'b0000_0101;
      step();
      check_out("tc_grant", 8'h04, 2, 1'b1, 1'b0);
      for (int i = 1; i < 4; i++) begin
         step();
         check_out($sformatf("tc_hold_%0d", i), 8'h04, 2, 1'b1, 1'b0);
      end
      step();
      check_out("tc_switch", 8'h01, 0, 1'b1, 1'b1);
      req = '0;
      step();
      check_out("tc_end", 8'h00, 0, 1'b0, 1'b0);

      // done coincides with the hold limit: normal release, no timeout
      req = 8'b0000_0100;
      step();
      check_out("dl_grant", 8'h04, 2, 1'b1, 1'b0);
      for (int i = 1; i < 4; i++) begin
         step();
         check_out($sformatf("dl_hold_%0d", i), 8'h04, 2, 1'b1, 1'b0);
      end
      done = 1'b1;
      step();
      check_out("dl_release", 8'h04, 2, 1'b1, 1'b0);
      done = 1'b0;
      req  = '0;
      step();
      check_out("dl_idle", 8'h00, 2, 1'b0, 1'b0);

      // Owner drops its request without done
      req = 8'b0010_0000;
      step();
      check_out("drop_grant", 8'h20, 5, 1'b1, 1'b0);
      req = '0;
      step();
      check_out("drop_release", 8'h00, 5, 1'b0, 1'b0);

      // Asynchronous reset mid-grant, then first round-robin grant from reset pointer
      req = 8'b0010_0000;
      step();
      check_out("rst_grant", 8'h20, 5, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_out("rst_mid", 8'h00, 0, 1'b0, 1'b0);
      #1;
      rst_n = 1'b1;
      mode  = MODE_RR;
      req   = 8'hFF;
      step();
      check_out("rst_rr_first", 8'h80, 7, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_rr_priority_arbiter

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Shares one resource among N requesters.
- Arbitration reuses MSB-first priority encoding; in round-robin mode a rotating pointer moves the priority window.
- Grant is registered and held until the owner releases it, drops its request, or exceeds a hold-time limit.
- Sits between requesting masters and a single shared datapath/bus.

Parameters:
- N, 8, number of requesters (power of 2, >=2)
- IDW, $clog2(N), width of requester index
- MAX_HOLD, 16, max cycles a grant may be held before forced release (>=2)
- CNTW, $clog2(MAX_HOLD), hold counter width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- mode  input  1  0 = fixed priority (index N-1 highest), 1 = round-robin
- req  input  N  request vector, level, held until served
- done  input  1  owner releases grant, single-cycle pulse
- gnt  output  N  one-hot grant, registered
- gnt_id  output  IDW  index of current owner, valid when gnt_valid
- gnt_valid  output  1  grant active
- timeout  output  1  one-cycle pulse: grant was force-released

Behaviour:
- Reset (async, rst_n=0): gnt=0, gnt_id=0, gnt_valid=0, timeout=0, hold_cnt=0, ptr=N-1, state=IDLE. Asserting reset mid-grant clears outputs immediately.
- States:
  - IDLE: no owner.
  - BUSY: owner = gnt_id.
- Arbitration (combinational, evaluated each cycle in IDLE and on release cycles in BUSY); mode is sampled only here:
  - mode=0: winner = highest set index of eligible req.
  - mode=1: priority order ptr, ptr-1, ..., 0, N-1, ..., ptr+1; winner = first set eligible bit.
  - Eligible = req, except the timed-out owner is masked for that one arbitration only.
- IDLE -> BUSY: any eligible req at an edge. gnt/gnt_id/gnt_valid update at that edge (1-cycle latency from req to gnt). ptr <= (winner==0) ? N-1 : winner-1, updated in both modes.
- Release conditions in BUSY, sampled at the edge, in priority order:
  - (a) done=1
  - (b) req[gnt_id]=0
  - (c) hold_cnt==MAX_HOLD-1 -> forced release, timeout=1 for the following cycle
  - done together with (c) counts as (a): no timeout pulse.
- On release:
  - Arbitrate the same edge, giving back-to-back grants with zero bubble.
  - If a winner exists: stay BUSY, load new gnt, update ptr, hold_cnt<=0.
  - Otherwise: go to IDLE, gnt=0, gnt_valid=0; gnt_id holds its last value.
- hold_cnt increments each BUSY cycle without release; clears on any new grant.
- done while IDLE is ignored. Requests from non-owners while BUSY wait; there is no preemption.
- Invariants, checked by assertions:
  - gnt is one-hot or zero.
  - gnt_valid == |gnt.
  - gnt[gnt_id]==1 when gnt_valid.
  - timeout only ever asserted for one cycle.

Decomposition:
- Package arb_pkg:
  - state enum {IDLE, BUSY}
  - mode constants MODE_FIXED=1'b0, MODE_RR=1'b1
- Sub-module rot_prio_enc (combinational):
  - Inputs: req vector and ptr.
  - Rotates req so that ptr lands at the MSB, MSB-first priority-encodes it, then un-rotates the index.
  - Outputs: found and idx.
  - Fixed mode drives it with ptr=N-1.
- Top level holds the FSM, ptr, hold counter and output registers.

Test Plan:
- Fixed mode: req=8'b0100_1000 -> next edge gnt=8'b0100_0000, gnt_id=6, gnt_valid=1. Then done -> gnt=8'b0000_1000, gnt_id=3 at the same edge, no bubble.
- Round-robin: req=8'hFF held, done pulsed every owned cycle -> gnt_id sequence 7,6,5,4,3,2,1,0,7; no id repeats before all 8 are served.
- Timeout, MAX_HOLD=4: only req[2] held, no done -> gnt_valid high 4 cycles, then gnt=0 and timeout=1 for one cycle, IDLE one cycle, then regrant id 2, hold_cnt=0.
- Timeout with contender, MAX_HOLD=4: req=8'b0000_0101, owner 2 -> forced release grants id 0 at the same edge, timeout=1 for one cycle.
- done and the hold limit in the same cycle -> release happens, timeout stays 0.
- Owner drops req[5] without done -> released at the next edge; rst_n pulled low mid-grant -> gnt=0 and gnt_valid=0 immediately; after reset release, the first RR grant with req=8'hFF is id 7.
